dot_product_engine: RTL
=======================

// Module: dot_product_engine
// PURPOSE
//   Multi-lane signed dot-product engine; successor to the single-lane MAC.
//   Each accepted beat multiplies LANES element pairs, sums them in a registered adder tree,
//     and adds the sum into a saturating accumulator.
//   After vec_len beats it presents one result on a valid/ready output port.
//   Sits between the operand buffers and the CNN output/activation stage.
// PARAMETERS
//   DATA_WIDTH  8   width of each signed operand element
//   ACC_WIDTH   32  signed accumulator/result width; must be >= 2*DATA_WIDTH+clog2(LANES)
//   LANES       4   element pairs consumed per beat
//   LEN_WIDTH   16  width of the beat-count field vec_len
// PORTS
//   clk        in   1                  clock; all state changes on rising edge
//   rst_n      in   1                  asynchronous, active-low reset
//   start      in   1                  launch a dot product; sampled only in IDLE
//   vec_len    in   LEN_WIDTH          number of beats in this dot product, latched on start
//   in_valid   in   1                  operand beat valid
//   in_ready   out  1                  engine accepts operand beat
//   a_vec      in   LANES*DATA_WIDTH   signed operands, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   b_vec      in   LANES*DATA_WIDTH   signed operands, same packing as a_vec
//   out_valid  out  1                  result valid
//   out_ready  in   1                  consumer takes result
//   result     out  ACC_WIDTH          signed dot product, saturated
//   sat        out  1                  result was clamped at least once during this operation
//   busy       out  1                  state != IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     state=IDLE; in_ready, out_valid, sat, busy, result=0; accumulator, beat counter and psum register cleared.
//   FSM states: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
//   IDLE: in_ready=0.
//     start=1 with vec_len!=0: latch vec_len, clear accumulator and sat, go to RUN.
//     start=1 with vec_len==0: clear accumulator and sat, go directly to DONE (result 0).
//   RUN: in_ready=1. A beat transfers when in_valid & in_ready.
//     On each beat: psum_r <= sum over lanes of a[i]*b[i]
//       (signed, full width 2*DATA_WIDTH+clog2(LANES), sign-extended).
//     psum_vld <= 1 on a beat, 0 otherwise.
//     Beat counter decrements per beat. On the last beat, go to FLUSH.
//     in_valid gaps stall the operation with no state change.
//   Accumulate: every cycle psum_vld=1, acc <= sat_add(acc, psum_r).
//     Sum is computed in ACC_WIDTH+1 bits.
//     Above 2^(ACC_WIDTH-1)-1: clamp to max and set sat. Below -2^(ACC_WIDTH-1): clamp to min and set sat.
//     sat is sticky until the next start.
//   FLUSH: in_ready=0; the final psum is added this cycle; go to DONE.
//   DONE: out_valid=1; result=acc and sat are held stable until out_ready=1.
//     On out_valid & out_ready, go to IDLE the next cycle (out_valid=0 then).
//     No combinational path from out_ready to out_valid.
//   Latency: last input handshake at edge E -> out_valid=1 after edge E+1 (2 cycles).
//     Throughput: 1 beat/cycle.
//   start outside IDLE is ignored. in_valid outside RUN is ignored (no beat consumed).
//   result holds the last value after the handshake and is cleared at the next start.
//   rst_n asserted in any state aborts the operation immediately.
//     After release, the next start runs correctly.
// TESTING
//   1. LANES=4, vec_len=2: beat a={1,2,3,4}, b={5,6,7,8}; then a={-1,-1,-1,-1}, b={2,2,2,2}
//      -> result=62, sat=0, out_valid exactly 2 cycles after the 2nd handshake.
//   2. Same as test 1 with in_valid low for 3 cycles between beats, and out_ready low for 5 cycles
//      -> result=62 held stable, in_ready=0 in DONE, start pulses ignored.
//   3. ACC_WIDTH=20, vec_len=9, all lanes a=127, b=127 -> result=524287, sat=1.
//      Then all lanes a=-128, b=127, vec_len=9 -> result=-524288, sat=1.
//   4. start with vec_len=0 -> out_valid=1 one cycle later, result=0, no in_ready pulse.
//   5. rst_n=0 for 1 cycle mid-RUN (after beat 1 of 3) -> all outputs 0 asynchronously, busy=0.
//      New run of test 1 -> 62.
//   6. Back-to-back: out_ready=1, start asserted the cycle after the output handshake
//      -> second result is independent of the first; sat is cleared.

Source files
------------

// File: rtl/dot_product_engine.sv
// Multi-lane signed dot-product engine.
// Registered lane-sum feeding a saturating accumulator.
module dot_product_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int LANES      = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [LEN_WIDTH-1:0]          vec_len,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   a_vec,
  input  logic [LANES*DATA_WIDTH-1:0]   b_vec,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_WIDTH-1:0]   result,
  output logic                          sat,
  output logic                          busy
);

  localparam int PRODW = 2 * DATA_WIDTH;
  localparam int PW    = PRODW + $clog2(LANES);
  localparam int SW    = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t                     state;
  logic [LEN_WIDTH-1:0]       cnt;
  logic signed [PW-1:0]       psum_r;
  logic                       psum_vld;
  logic signed [ACC_WIDTH-1:0] acc;

  logic signed [DATA_WIDTH-1:0] a_l [LANES];
  logic signed [DATA_WIDTH-1:0] b_l [LANES];
  logic signed [PRODW-1:0]      prod [LANES];
  logic signed [PW-1:0]         psum_c;
  logic signed [SW-1:0]         sum;
  logic signed [ACC_WIDTH-1:0]  sat_val;
  logic                         ovf;
  logic                         beat;

  assign beat = in_valid & in_ready;

  // Lane products summed at full precision, no truncation.
  always_comb begin
    psum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      a_l[i]  = a_vec[i*DATA_WIDTH +: DATA_WIDTH];
      b_l[i]  = b_vec[i*DATA_WIDTH +: DATA_WIDTH];
      prod[i] = PRODW'(a_l[i]) * PRODW'(b_l[i]);
      psum_c  = psum_c + PW'(prod[i]);
    end
  end

  // One extra bit catches overflow; clamp toward the overflowing side.
  always_comb begin
    sum     = SW'(acc) + SW'(psum_r);
    ovf     = sum[SW-1] != sum[SW-2];
    sat_val = sum[ACC_WIDTH-1:0];
    if (ovf) begin
      if (sum[SW-1]) begin
        sat_val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        sat_val = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
  end

  // Control FSM, psum pipeline and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      psum_r    <= '0;
      psum_vld  <= 1'b0;
      acc       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      psum_vld <= beat;
      if (beat) begin
        psum_r <= psum_c;
      end
      if (psum_vld) begin
        acc <= sat_val;
        if (ovf) begin
          sat <= 1'b1;
        end
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            sat    <= 1'b0;
            result <= '0;
            busy   <= 1'b1;
            if (vec_len != '0) begin
              cnt      <= vec_len;
              in_ready <= 1'b1;
              state    <= RUN;
            end else begin
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        RUN: begin
          if (beat) begin
            cnt <= cnt - LEN_WIDTH'(1);
            if (cnt == LEN_WIDTH'(1)) begin
              in_ready <= 1'b0;
              state    <= FLUSH;
            end
          end
        end
        FLUSH: begin
          result    <= psum_vld ? sat_val : acc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
